hd_program_loader: RTL and testbench

Sequential loader that copies a contiguous run of 32-bit words from the hard disk (DiscoRigido) into instruction memory, one sector per word, starting at a given track/sector. It is the reading end of the disk path: the processor writes programs to disk through the register-driven track/sector/data port, and this block reads them back and commits them via the instruction-write port (InstDst/InstWrite) before a context switch. It sits beside UnidadeProcessamento, is started by the control path, and owns the HD address lines while Busy.

---
 rtl/cpu_pkg.sv | 6 +
 rtl/loader_latency_counter.sv | 20 ++
 rtl/hd_program_loader.sv | 101 ++++++++++
 tb/tb_hd_program_loader.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: types and widths shared by the processor-side disk loader path
package cpu_pkg;
    localparam int WORD_W = 32;
    localparam int HD_AW = 32;
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WRITE, FINISH} loader_state_t;
endpackage

// File: rtl/loader_latency_counter.sv
// loader_latency_counter: counts down a fixed disk read latency after an address is issued
module loader_latency_counter #(
    parameter int LATENCY = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic expire
);
    localparam int W = $clog2(LATENCY + 1);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else if (load) cnt <= W'(LATENCY);
        else if (dec && cnt != '0) cnt <= cnt - W'(1);
    end
    // flags the last wait cycle: the decrement taken on this edge reaches zero
    assign expire = cnt == W'(1);
endmodule

// File: rtl/hd_program_loader.sv
// hd_program_loader: copies consecutive disk sectors into instruction memory, one word per sector
// Defining LOADER_CHECKSUM_EN adds a running sum of the loaded words on Checksum.
module hd_program_loader
    import cpu_pkg::*;
#(
    parameter int IMEM_AW = 10,
    parameter int READ_LATENCY = 2
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic                Start,
    input  logic [HD_AW-1:0]    Track,
    input  logic [HD_AW-1:0]    FirstSector,
    input  logic [IMEM_AW:0]    WordCount,
    input  logic [IMEM_AW-1:0]  DestAddr,
    output logic [HD_AW-1:0]    HdTrilha,
    output logic [HD_AW-1:0]    HdSetor,
    input  logic [WORD_W-1:0]   HdQ,
    output logic [IMEM_AW-1:0]  InstAddr,
    output logic [WORD_W-1:0]   InstData,
    output logic                InstWrite,
    output logic                Busy,
    output logic                Done,
    output logic                Error,
    output logic [WORD_W-1:0]   Checksum
);
    loader_state_t state, next;
    logic [IMEM_AW:0] remaining;
    logic [IMEM_AW+1:0] end_addr;
    logic fits, accept, expire;

    assign end_addr = {2'b00, DestAddr} + {1'b0, WordCount};
    assign fits = end_addr <= {2'b01, {IMEM_AW{1'b0}}};
    assign accept = state == IDLE && next == ISSUE;
    assign InstWrite = state == WRITE;
    assign Busy = state != IDLE;
    assign Done = state == FINISH;

    loader_latency_counter #(.LATENCY(READ_LATENCY)) u_latency (
        .clk(CLK),
        .rst(Reset),
        .load(state == ISSUE),
        .dec(state == WAIT),
        .expire(expire)
    );

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) state <= IDLE;
        else state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = !Start ? IDLE : WordCount == '0 ? FINISH : fits ? ISSUE : IDLE;
            ISSUE:   next = WAIT;
            WAIT:    next = expire ? WRITE : WAIT;
            WRITE:   next = remaining == (IMEM_AW+1)'(1) ? FINISH : ISSUE;
            FINISH:  next = IDLE;
            default: next = IDLE;
        endcase
    end

    // HD address registers double as the latched track/sector, so they only move on real reads
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            HdTrilha <= '0;
            HdSetor <= '0;
            InstAddr <= '0;
            InstData <= '0;
            remaining <= '0;
            Error <= 1'b0;
        end else begin
            Error <= state == IDLE && Start && WordCount != '0 && !fits;
            if (accept) begin
                HdTrilha <= Track;
                HdSetor <= FirstSector;
                InstAddr <= DestAddr;
                remaining <= WordCount;
            end
            if (state == WAIT && expire) InstData <= HdQ;
            if (InstWrite) begin
                HdSetor <= HdSetor + 32'd1;
                InstAddr <= InstAddr + IMEM_AW'(1);
                remaining <= remaining - (IMEM_AW+1)'(1);
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [WORD_W-1:0] sum;
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) sum <= '0;
        else if (accept) sum <= '0;
        else if (InstWrite) sum <= sum + InstData;
    end
    assign Checksum = sum;
`else
    assign Checksum = '0;
`endif
endmodule

// File: tb/tb_hd_program_loader.sv
// tb_hd_program_loader: scoreboard bench for the disk-to-instruction-memory loader
module tb_hd_program_loader;
    localparam int AW = 10;
    localparam int RL = 2;

    logic CLK = 0, Reset = 1, Start = 0;
    logic [31:0] Track = 0, FirstSector = 0;
    logic [AW:0] WordCount = 0;
    logic [AW-1:0] DestAddr = 0;
    logic [31:0] HdTrilha, HdSetor, HdQ, InstData, Checksum;
    logic [AW-1:0] InstAddr;
    logic InstWrite, Busy, Done, Error;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [31:0] d;
        logic [31:0] s;
        logic [31:0] t;
        logic [31:0] c;
    } wr_t;

    wr_t expq[$];
    wr_t obs[$];
    int vecs = 0, errs = 0, rd = 0;
    int cyc = 0, done_n = 0, done_at = 0, err_n = 0, err_at = 0, busy_n = 0;
    logic [31:0] q1 = 0, q2 = 0;

    hd_program_loader #(.IMEM_AW(AW), .READ_LATENCY(RL)) dut (
        .CLK(CLK), .Reset(Reset), .Start(Start), .Track(Track), .FirstSector(FirstSector),
        .WordCount(WordCount), .DestAddr(DestAddr), .HdTrilha(HdTrilha), .HdSetor(HdSetor),
        .HdQ(HdQ), .InstAddr(InstAddr), .InstData(InstData), .InstWrite(InstWrite),
        .Busy(Busy), .Done(Done), .Error(Error), .Checksum(Checksum)
    );

    always #5 CLK = ~CLK;

    // disk model: data for sector s is 0xA0+s, valid two cycles after the address
    always @(posedge CLK) begin
        cyc <= cyc + 1;
        q1 <= 32'hA0 + HdSetor;
        q2 <= q1;
    end
    assign HdQ = q2;

    always @(negedge CLK) begin
        if (InstWrite) obs.push_back('{a: InstAddr, d: InstData, s: HdSetor, t: HdTrilha, c: 32'(cyc)});
        if (Done) begin done_n++; done_at = cyc; end
        if (Error) begin err_n++; err_at = cyc; end
        if (Busy) busy_n++;
    end

    task automatic start_req(input logic [31:0] trk, input logic [31:0] sec, input logic [AW:0] n,
                             input logic [AW-1:0] dst, output int t0);
        @(negedge CLK);
        Track = trk; FirstSector = sec; WordCount = n; DestAddr = dst; Start = 1; t0 = cyc;
        @(negedge CLK);
        Start = 0;
    endtask

    task automatic push_exp(input logic [31:0] trk, input logic [31:0] sec, input int n,
                            input logic [AW-1:0] dst, input int t0);
        for (int i = 0; i < n; i++)
            expq.push_back('{a: dst + AW'(i), d: 32'hA0 + sec + 32'(i), s: sec + 32'(i), t: trk,
                             c: 32'(t0 + (RL + 2) * (i + 1))});
    endtask

    task automatic wait_done(input int d0, output bit ok);
        ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge CLK);
            if (done_n > d0) ok = 1;
        end
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_reset;
        Reset = 1;
        repeat (2) @(negedge CLK);
        vecs++;
        if ({HdTrilha, HdSetor, InstAddr, InstData, Checksum, InstWrite, Busy, Done, Error} !== '0) begin
            errs++;
            $display("FAIL reset outputs: got trk=%h sec=%h addr=%h data=%h ck=%h wr=%b busy=%b done=%b err=%b, want all 0",
                     HdTrilha, HdSetor, InstAddr, InstData, Checksum, InstWrite, Busy, Done, Error);
        end
        Reset = 0;
        @(negedge CLK);
    endtask

    task automatic test_basic;
        int t0, d0;
        bit ok;
        wr_t e;
        logic [31:0] ck;
        d0 = done_n;
        start_req(32'd3, 32'd10, 11'd4, 10'h20, t0);
        push_exp(32'd3, 32'd10, 4, 10'h20, t0);
        ck = 0;
        foreach (expq[i]) ck += expq[i].d;
`ifndef LOADER_CHECKSUM_EN
        ck = 0;
`endif
        wait_done(d0, ok);
        vecs++;
        if (!ok) begin errs++; $display("FAIL basic done timeout: got no Done, want Done"); end
        vecs++;
        if (done_at !== t0 + 17) begin errs++; $display("FAIL basic done cycle: got %0d, want %0d", done_at - t0, 17); end
        vecs++;
        if (done_n - d0 !== 1) begin errs++; $display("FAIL basic done count: got %0d, want 1", done_n - d0); end
        vecs++;
        if (Checksum !== ck) begin errs++; $display("FAIL basic checksum: got %h, want %h", Checksum, ck); end
        while (expq.size() > 0) begin
            e = expq.pop_front();
            vecs++;
            if (rd >= obs.size() || obs[rd] !== e) begin
                errs++;
                $display("FAIL basic write: got %h, want %h", (rd < obs.size()) ? obs[rd] : wr_t'(0), e);
            end
            rd++;
        end
        vecs++;
        if (obs.size() != rd) begin errs++; $display("FAIL basic extra writes: got %0d, want %0d", obs.size(), rd); end
    endtask

    task automatic test_zero;
        int t0, d0, b0;
        bit ok;
        logic [31:0] ht, hs;
        d0 = done_n; b0 = busy_n; ht = HdTrilha; hs = HdSetor;
        start_req(32'd9, 32'd77, 11'd0, 10'h50, t0);
        wait_done(d0, ok);
        vecs++;
        if (!ok || done_at !== t0 + 1) begin errs++; $display("FAIL zero done cycle: got %0d ok=%0d, want 1", done_at - t0, ok); end
        vecs++;
        if (busy_n - b0 !== 1) begin errs++; $display("FAIL zero busy cycles: got %0d, want 1", busy_n - b0); end
        vecs++;
        if (HdTrilha !== ht || HdSetor !== hs) begin
            errs++;
            $display("FAIL zero hd address: got %h/%h, want %h/%h", HdTrilha, HdSetor, ht, hs);
        end
        vecs++;
        if (obs.size() != rd) begin errs++; $display("FAIL zero writes: got %0d, want %0d", obs.size(), rd); end
    endtask

    task automatic test_bounds;
        int t0, d0, b0, e0;
        bit ok;
        wr_t e;
        b0 = busy_n; e0 = err_n;
        start_req(32'd1, 32'd200, 11'd3, 10'h3FE, t0);
        repeat (4) @(negedge CLK);
        vecs++;
        if (err_n - e0 !== 1 || err_at !== t0 + 1) begin
            errs++;
            $display("FAIL bounds error pulse: got count %0d at %0d, want 1 at 1", err_n - e0, err_at - t0);
        end
        vecs++;
        if (busy_n !== b0) begin errs++; $display("FAIL bounds busy: got %0d cycles, want 0", busy_n - b0); end
        vecs++;
        if (obs.size() != rd) begin errs++; $display("FAIL bounds rejected writes: got %0d, want %0d", obs.size(), rd); end
        d0 = done_n;
        start_req(32'd1, 32'd200, 11'd2, 10'h3FE, t0);
        push_exp(32'd1, 32'd200, 2, 10'h3FE, t0);
        wait_done(d0, ok);
        vecs++;
        if (!ok || done_at !== t0 + 9) begin errs++; $display("FAIL bounds done: got %0d ok=%0d, want 9", done_at - t0, ok); end
        while (expq.size() > 0) begin
            e = expq.pop_front();
            vecs++;
            if (rd >= obs.size() || obs[rd] !== e) begin
                errs++;
                $display("FAIL bounds write: got %h, want %h", (rd < obs.size()) ? obs[rd] : wr_t'(0), e);
            end
            rd++;
        end
    endtask

    task automatic test_sector_wrap;
        int t0, d0;
        bit ok;
        wr_t e;
        d0 = done_n;
        start_req(32'd7, 32'hFFFF_FFFF, 11'd2, 10'h60, t0);
        push_exp(32'd7, 32'hFFFF_FFFF, 2, 10'h60, t0);
        wait_done(d0, ok);
        vecs++;
        if (!ok) begin errs++; $display("FAIL wrap done timeout: got no Done, want Done"); end
        while (expq.size() > 0) begin
            e = expq.pop_front();
            vecs++;
            if (rd >= obs.size() || obs[rd] !== e) begin
                errs++;
                $display("FAIL wrap write: got %h, want %h", (rd < obs.size()) ? obs[rd] : wr_t'(0), e);
            end
            rd++;
        end
        vecs++;
        if (Error !== 1'b0 || err_at > t0) begin errs++; $display("FAIL wrap error: got err_at %0d, want none", err_at - t0); end
    endtask

    task automatic test_back_to_back;
        int t0, d0;
        bit ok;
        wr_t e;
        d0 = done_n;
        start_req(32'd5, 32'd40, 11'd3, 10'h80, t0);
        push_exp(32'd5, 32'd40, 3, 10'h80, t0);
        repeat (3) @(negedge CLK);
        Track = 99; FirstSector = 1000; WordCount = 5; DestAddr = 10'h200; Start = 1;
        @(negedge CLK);
        Start = 0;
        repeat (8) @(negedge CLK);
        vecs++;
        if (Done !== 1'b1) begin errs++; $display("FAIL b2b finish state: got Done=%b, want 1", Done); end
        Start = 1;
        @(negedge CLK);
        Start = 0;
        wait_done(d0, ok);
        repeat (20) @(negedge CLK);
        vecs++;
        if (done_n - d0 !== 1) begin errs++; $display("FAIL b2b done count: got %0d, want 1", done_n - d0); end
        vecs++;
        if (Busy !== 1'b0) begin errs++; $display("FAIL b2b busy after: got %b, want 0", Busy); end
        while (expq.size() > 0) begin
            e = expq.pop_front();
            vecs++;
            if (rd >= obs.size() || obs[rd] !== e) begin
                errs++;
                $display("FAIL b2b write: got %h, want %h", (rd < obs.size()) ? obs[rd] : wr_t'(0), e);
            end
            rd++;
        end
        vecs++;
        if (obs.size() != rd) begin errs++; $display("FAIL b2b extra writes: got %0d, want %0d", obs.size(), rd); end
    endtask

    task automatic test_reset_mid;
        int t0, d0;
        bit ok;
        wr_t e;
        logic [31:0] ck;
        d0 = done_n;
        start_req(32'd2, 32'd50, 11'd4, 10'h100, t0);
        push_exp(32'd2, 32'd50, 1, 10'h100, t0);
        repeat (5) @(negedge CLK);
        #2 Reset = 1;
        #1;
        vecs++;
        if ({HdTrilha, HdSetor, InstAddr, InstData, Checksum, InstWrite, Busy, Done, Error} !== '0) begin
            errs++;
            $display("FAIL midreset outputs: got trk=%h sec=%h addr=%h data=%h ck=%h wr=%b busy=%b done=%b err=%b, want all 0",
                     HdTrilha, HdSetor, InstAddr, InstData, Checksum, InstWrite, Busy, Done, Error);
        end
        @(negedge CLK);
        Reset = 0;
        @(negedge CLK);
        vecs++;
        if (done_n !== d0) begin errs++; $display("FAIL midreset done: got %0d pulses, want 0", done_n - d0); end
        start_req(32'd2, 32'd60, 11'd3, 10'h140, t0);
        push_exp(32'd2, 32'd60, 3, 10'h140, t0);
        ck = 32'hDC + 32'hDD + 32'hDE;
`ifndef LOADER_CHECKSUM_EN
        ck = 0;
`endif
        wait_done(d0, ok);
        vecs++;
        if (!ok || done_at !== t0 + 13) begin errs++; $display("FAIL midreset rerun done: got %0d ok=%0d, want 13", done_at - t0, ok); end
        vecs++;
        if (Checksum !== ck) begin errs++; $display("FAIL midreset checksum: got %h, want %h", Checksum, ck); end
        while (expq.size() > 0) begin
            e = expq.pop_front();
            vecs++;
            if (rd >= obs.size() || obs[rd] !== e) begin
                errs++;
                $display("FAIL midreset write: got %h, want %h", (rd < obs.size()) ? obs[rd] : wr_t'(0), e);
            end
            rd++;
        end
        vecs++;
        if (obs.size() != rd) begin errs++; $display("FAIL midreset extra writes: got %0d, want %0d", obs.size(), rd); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_zero;
        test_bounds;
        test_sector_wrap;
        test_back_to_back;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
